// File: rtl/turbofm_pkg.sv
// Shared types for the YM/SAA bus sequencer: device codes, FSM states,
// the buffered request record and the idle level of the chip strobe pins.
package turbofm_pkg;

  typedef enum logic [1:0] {
    DEV_YM1  = 2'd0,
    DEV_YM2  = 2'd1,
    DEV_SAA  = 2'd2,
    DEV_NONE = 2'd3
  } dev_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAITRDY = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  localparam int unsigned DEF_T_SETUP      = 32'd1;
  localparam int unsigned DEF_T_STROBE     = 32'd4;
  localparam int unsigned DEF_T_HOLD       = 32'd1;
  localparam int unsigned DEF_YM_ADDR_WAIT = 32'd137;
  localparam int unsigned DEF_YM_DATA_WAIT = 32'd664;

  typedef struct packed {
    logic       wr;
    dev_e       dev;
    logic       a0;
    logic [7:0] wdata;
  } req_t;

  typedef struct packed {
    logic ymcs1_n;
    logic ymcs2_n;
    logic ymrd_n;
    logic ymwr_n;
    logic yma0;
    logic saacs_n;
    logic saawr_n;
    logic saaa0;
  } pins_t;

  localparam pins_t PINS_IDLE = 8'b1111_0110;

  function automatic logic is_ym(input dev_e d);
    return (d == DEV_YM1) || (d == DEV_YM2);
  endfunction

endpackage

// File: rtl/ym_bus_sequencer_if.sv
// Request side and chip-bus side of the sequencer; the sequencer is the slave,
// the AY bus decoder / chip models are the master.
interface ym_bus_sequencer_if;
  logic       req_valid;
  logic       req_wr;
  logic [1:0] req_dev;
  logic       req_a0;
  logic [7:0] req_wdata;
  logic       busy;
  logic       overrun;
  logic       ovr_clr;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ymcs1_n;
  logic       ymcs2_n;
  logic       ymrd_n;
  logic       ymwr_n;
  logic       yma0;
  logic       saacs_n;
  logic       saawr_n;
  logic       saaa0;

  modport slave (
    input  req_valid, req_wr, req_dev, req_a0, req_wdata, ovr_clr, d_in,
    output busy, overrun, d_out, d_oe, rd_data, rd_valid,
           ymcs1_n, ymcs2_n, ymrd_n, ymwr_n, yma0, saacs_n, saawr_n, saaa0
  );

  modport master (
    output req_valid, req_wr, req_dev, req_a0, req_wdata, ovr_clr, d_in,
    input  busy, overrun, d_out, d_oe, rd_data, rd_valid,
           ymcs1_n, ymcs2_n, ymrd_n, ymwr_n, yma0, saacs_n, saawr_n, saaa0
  );
endinterface

// File: rtl/ym_recovery_timer.sv
// Per-chip busy timer: loaded after a write, counts down to zero and holds there.
module ym_recovery_timer (
  input  logic       fclk,
  input  logic       ayres_n,
  input  logic       load,
  input  logic [9:0] load_val,
  output logic       ready
);
  logic [9:0] count_q, count_d;

  // reload on a finished write, otherwise saturating decrement
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != 10'd0) begin
      count_d = count_q - 10'd1;
    end else begin
      count_d = 10'd0;
    end
  end

  // count register
  always_ff @(posedge fclk or negedge ayres_n) begin
    if (!ayres_n) begin
      count_q <= 10'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign ready = (count_q == 10'd0);
endmodule

// File: rtl/ym_bus_sequencer.sv
// Turns one-cycle AY bus requests into timed CS/A0/strobe cycles on the two YM
// chips and the SAA, honouring each YM chip's post-write recovery time.
module ym_bus_sequencer
  import turbofm_pkg::*;
#(
  parameter int unsigned T_SETUP      = DEF_T_SETUP,
  parameter int unsigned T_STROBE     = DEF_T_STROBE,
  parameter int unsigned T_HOLD       = DEF_T_HOLD,
  parameter int unsigned YM_ADDR_WAIT = DEF_YM_ADDR_WAIT,
  parameter int unsigned YM_DATA_WAIT = DEF_YM_DATA_WAIT
) (
  input logic               fclk,
  input logic               ayres_n,
  ym_bus_sequencer_if.slave bus
);
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t       buf_q, buf_d, cur_q, cur_d, req_in;
  logic       buf_full_q, buf_full_d, overrun_q, overrun_d, busy_q, busy_d;
  logic [7:0] rd_data_q, rd_data_d, d_out_q, d_out_d;
  logic       rd_valid_q, rd_valid_d, d_oe_q, d_oe_d;
  pins_t      pins_q, pins_d;
  logic       req_ok, consume, can_load, tgt_ready, status_rd, capture;
  logic       ld_ym1, ld_ym2, ym1_ready, ym2_ready, cs_act, strobe_act;
  logic [9:0] rec_val;

  // request buffer; a request landing on the consume edge still gets in
  always_comb begin
    req_in     = '{wr: bus.req_wr, dev: dev_e'(bus.req_dev), a0: bus.req_a0, wdata: bus.req_wdata};
    req_ok     = bus.req_valid && (req_in.dev != DEV_NONE);
    consume    = (state_q == ST_IDLE) && buf_full_q;
    can_load   = !buf_full_q || consume;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (req_ok && can_load && !((req_in.dev == DEV_SAA) && !req_in.wr)) begin
      buf_d      = req_in;
      buf_full_d = 1'b1;
    end else if (consume) begin
      buf_full_d = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end
    if (req_ok && !can_load) begin
      overrun_d = 1'b1;
    end else if (bus.ovr_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // sequencing FSM; status reads bypass the recovery wait
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    capture   = 1'b0;
    ld_ym1    = 1'b0;
    ld_ym2    = 1'b0;
    rec_val   = cur_q.a0 ? 10'(YM_DATA_WAIT) : 10'(YM_ADDR_WAIT);
    status_rd = is_ym(cur_q.dev) && !cur_q.wr && !cur_q.a0;
    case (cur_q.dev)
      DEV_YM1: tgt_ready = ym1_ready || status_rd;
      DEV_YM2: tgt_ready = ym2_ready || status_rd;
      default: tgt_ready = 1'b1;
    endcase
    case (state_q)
      ST_IDLE: begin
        if (buf_full_q) begin
          state_d = ST_WAITRDY;
          cur_d   = buf_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAITRDY: begin
        if (tgt_ready) begin
          state_d = ST_SETUP;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_WAITRDY;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'(T_SETUP - 32'd1)) begin
          state_d = ST_STROBE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'(T_STROBE - 32'd1)) begin
          state_d = ST_HOLD;
          cnt_d   = 4'd0;
          capture = !cur_q.wr;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'(T_HOLD - 32'd1)) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          ld_ym1  = cur_q.wr && (cur_q.dev == DEV_YM1);
          ld_ym2  = cur_q.wr && (cur_q.dev == DEV_YM2);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // pin levels follow the next state so every output leaves a flop
  always_comb begin
    cs_act     = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    strobe_act = (state_d == ST_STROBE);
    pins_d     = PINS_IDLE;
    if (cs_act) begin
      case (cur_d.dev)
        DEV_YM1: begin
          pins_d.ymcs1_n = 1'b0;
          pins_d.yma0    = cur_d.a0;
          pins_d.ymwr_n  = !(strobe_act && cur_d.wr);
          pins_d.ymrd_n  = !(strobe_act && !cur_d.wr);
        end
        DEV_YM2: begin
          pins_d.ymcs2_n = 1'b0;
          pins_d.yma0    = cur_d.a0;
          pins_d.ymwr_n  = !(strobe_act && cur_d.wr);
          pins_d.ymrd_n  = !(strobe_act && !cur_d.wr);
        end
        DEV_SAA: begin
          pins_d.saacs_n = 1'b0;
          pins_d.saaa0   = cur_d.a0;
          pins_d.saawr_n = !(strobe_act && cur_d.wr);
        end
        default: pins_d = PINS_IDLE;
      endcase
    end else begin
      pins_d = PINS_IDLE;
    end
    d_oe_d     = cs_act && cur_d.wr && (cur_d.dev != DEV_NONE);
    d_out_d    = d_oe_d ? cur_d.wdata : 8'h00;
    busy_d     = buf_full_d || (state_d != ST_IDLE);
    rd_valid_d = capture;
    rd_data_d  = capture ? bus.d_in : rd_data_q;
  end

  // state and output registers
  always_ff @(posedge fclk or negedge ayres_n) begin
    if (!ayres_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      buf_q      <= '0;
      cur_q      <= '0;
      buf_full_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      d_out_q    <= 8'h00;
      d_oe_q     <= 1'b0;
      pins_q     <= PINS_IDLE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      cur_q      <= cur_d;
      buf_full_q <= buf_full_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      d_out_q    <= d_out_d;
      d_oe_q     <= d_oe_d;
      pins_q     <= pins_d;
    end
  end

  ym_recovery_timer u_rec_ym1 (.fclk(fclk), .ayres_n(ayres_n), .load(ld_ym1), .load_val(rec_val), .ready(ym1_ready));
  ym_recovery_timer u_rec_ym2 (.fclk(fclk), .ayres_n(ayres_n), .load(ld_ym2), .load_val(rec_val), .ready(ym2_ready));

  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;
  assign bus.d_out    = d_out_q;
  assign bus.d_oe     = d_oe_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ymcs1_n  = pins_q.ymcs1_n;
  assign bus.ymcs2_n  = pins_q.ymcs2_n;
  assign bus.ymrd_n   = pins_q.ymrd_n;
  assign bus.ymwr_n   = pins_q.ymwr_n;
  assign bus.yma0     = pins_q.yma0;
  assign bus.saacs_n  = pins_q.saacs_n;
  assign bus.saawr_n  = pins_q.saawr_n;
  assign bus.saaa0    = pins_q.saaa0;
endmodule

// File: tb/tb_ym_bus_sequencer.sv
// Randomized and directed bench: a transaction-level model predicts every bus
// cycle (timing, target, data) and a pin monitor compares what actually happens.
module tb_ym_bus_sequencer;
  localparam int T_SETUP = 1, T_STROBE = 4, T_HOLD = 1, ADDR_W = 137, DATA_W = 664;

  logic fclk = 1'b0;
  logic ayres_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0, n_errors = 0;

  ym_bus_sequencer_if bus();

  ym_bus_sequencer #(.T_SETUP(T_SETUP), .T_STROBE(T_STROBE), .T_HOLD(T_HOLD),
                     .YM_ADDR_WAIT(ADDR_W), .YM_DATA_WAIT(DATA_W))
    dut (.fclk(fclk), .ayres_n(ayres_n), .bus(bus));

  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc <= cyc + 1;

  typedef struct { int fall; int idle; int dev; bit wr; bit a0; logic [7:0] data; } exp_t;
  typedef struct { int at; logic [7:0] data; } rd_t;
  exp_t expq[$];
  rd_t  rdq[$];

  // model state: cycle numbers are posedge counts
  int last_consume = 0, last_idle = 0, last_r = 0;
  int rec_until[2] = '{0, 0};
  bit exp_ovr = 1'b0;
  int last_fall[3] = '{0, 0, 0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Drive a one-cycle request (called just after a posedge) and predict its bus cycle.
  task automatic issue(input int dev, input bit wr, input bit a0, input logic [7:0] data, input logic [7:0] din);
    int r, k, fall, idle;
    exp_t x;
    rd_t  rd;
    r = cyc + 1;
    last_r = r;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_dev   = 2'(dev);
    bus.req_a0    = a0;
    bus.req_wdata = data;
    if (!wr) bus.d_in = din;
    if (dev != 3) begin
      if (r < last_consume) begin
        exp_ovr = 1'b1;
      end else if (!(dev == 2 && !wr)) begin
        // buffer drains one edge after the FSM is idle, then WAITRDY, then SETUP
        last_consume = imax(r, last_idle) + 1;
        k = last_consume + 1;
        if (dev < 2 && !(!wr && !a0)) k = imax(k, rec_until[dev] + 1);
        fall = k + T_SETUP;
        idle = fall + T_STROBE + T_HOLD;
        last_idle = idle;
        if (dev < 2 && wr) rec_until[dev] = idle + (a0 ? DATA_W : ADDR_W);
        x = '{fall: fall, idle: idle, dev: dev, wr: wr, a0: a0, data: data};
        expq.push_back(x);
        if (!wr) begin
          rd = '{at: fall + T_STROBE, data: din};
          rdq.push_back(rd);
        end
      end
    end
    @(posedge fclk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge fclk);
    while (bus.busy && n < 3000) begin
      @(negedge fclk);
      n++;
    end
    check_eq({tag, "_idle_at"}, cyc, imax(last_idle, last_r));
    check_eq({tag, "_overrun"}, bus.overrun, exp_ovr);
    @(posedge fclk); #1;
  endtask

  task automatic clear_ovr();
    bus.ovr_clr = 1'b1;
    @(posedge fclk); #1;
    bus.ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    @(negedge fclk);
    check_eq("ovr_cleared", bus.overrun, 1'b0);
    @(posedge fclk); #1;
  endtask

  function automatic logic [7:0] pin_vec();
    return {bus.ymcs1_n, bus.ymcs2_n, bus.ymrd_n, bus.ymwr_n, bus.saacs_n, bus.saawr_n, bus.yma0, bus.saaa0};
  endfunction

  // pin monitor: invariants every cycle, per-transaction comparison on strobe edges
  initial begin : monitor
    bit   strb, strb_prev, cs_any, cs_prev, cur_ok;
    int   n_cs, strb_len, dev_seen;
    exp_t cur;
    rd_t  rd;
    strb_prev = 1'b0; cs_prev = 1'b0; cur_ok = 1'b0; strb_len = 0;
    forever begin
      @(negedge fclk);
      if (!ayres_n) begin
        strb_prev = 1'b0; cs_prev = 1'b0; cur_ok = 1'b0; strb_len = 0;
      end else begin
        n_cs = int'(!bus.ymcs1_n) + int'(!bus.ymcs2_n) + int'(!bus.saacs_n);
        check_eq("cs_onehot", n_cs <= 1, 1'b1);
        check_eq("strobe_without_cs",
                 ((!bus.ymwr_n || !bus.ymrd_n) && bus.ymcs1_n && bus.ymcs2_n) || (!bus.saawr_n && bus.saacs_n), 1'b0);
        strb   = !bus.ymwr_n || !bus.ymrd_n || !bus.saawr_n;
        cs_any = (n_cs != 0);
        if (strb && !strb_prev) begin
          dev_seen = !bus.ymcs1_n ? 0 : (!bus.ymcs2_n ? 1 : (!bus.saacs_n ? 2 : 3));
          last_fall[dev_seen % 3] = cyc;
          check_eq("strobe_expected", expq.size() != 0, 1'b1);
          if (expq.size() != 0) begin
            cur = expq.pop_front();
            cur_ok = 1'b1;
            check_eq("fall_cycle", cyc, cur.fall);
            check_eq("target", dev_seen, cur.dev);
            check_eq("is_write", !bus.ymwr_n || !bus.saawr_n, cur.wr);
            check_eq("a0", (cur.dev == 2) ? bus.saaa0 : bus.yma0, cur.a0);
            check_eq("d_oe", bus.d_oe, cur.wr);
            if (cur.wr) check_eq("d_out", bus.d_out, cur.data);
          end
          strb_len = 0;
        end
        if (strb) strb_len++;
        if (!strb && strb_prev) check_eq("strobe_len", strb_len, T_STROBE);
        if (!cs_any && cs_prev && cur_ok) begin
          check_eq("cs_release", cyc, cur.idle);
          cur_ok = 1'b0;
        end
        if (bus.rd_valid) begin
          check_eq("rd_valid_expected", rdq.size() != 0, 1'b1);
          if (rdq.size() != 0) begin
            rd = rdq.pop_front();
            check_eq("rd_valid_cycle", cyc, rd.at);
            check_eq("rd_data", bus.rd_data, rd.data);
          end
        end
        strb_prev = strb;
        cs_prev   = cs_any;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int h1, n, dev, dev_b, g;
    bit wr, a0, wr_b;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_dev = 2'd3; bus.req_a0 = 1'b0;
    bus.req_wdata = 8'h00; bus.ovr_clr = 1'b0; bus.d_in = 8'h00;

    repeat (3) @(negedge fclk);
    check_eq("rst_pins", pin_vec(), 8'hFC);
    check_eq("rst_d_oe_busy_ovr", {bus.d_oe, bus.busy, bus.overrun, bus.rd_valid}, 4'h0);
    check_eq("rst_d_out_rd_data", {bus.d_out, bus.rd_data}, 16'h0000);
    @(posedge fclk); #2 ayres_n = 1'b1;
    @(posedge fclk); #1;

    // YM1 address write, YM2 write during YM1 recovery, then YM1 data write
    issue(0, 1'b1, 1'b0, 8'h2D, 8'h00);
    wait_idle("ym1_addr");
    h1 = last_idle;
    issue(1, 1'b1, 1'b1, 8'h5A, 8'h00);
    wait_idle("ym2_unblocked");
    check_eq("ym2_not_delayed", last_fall[1], last_r + T_SETUP + 2);
    issue(0, 1'b1, 1'b1, 8'h99, 8'h00);
    wait_idle("ym1_data");
    check_eq("ym1_recovery_gap", (last_fall[0] - h1) >= ADDR_W, 1'b1);

    // YM2 data read
    issue(1, 1'b0, 1'b1, 8'h00, 8'hA5);
    wait_idle("ym2_read");

    // three back-to-back requests to YM1; the third collides with ovr_clr
    issue(0, 1'b1, 1'b1, 8'h11, 8'h00);
    issue(0, 1'b1, 1'b1, 8'h22, 8'h00);
    bus.ovr_clr = 1'b1;
    issue(0, 1'b1, 1'b1, 8'h33, 8'h00);
    bus.ovr_clr = 1'b0;
    wait_idle("ovr_burst");
    clear_ovr();

    // SAA back-to-back writes, SAA read, and a request to no device
    issue(2, 1'b1, 1'b1, 8'h1C, 8'h00);
    issue(2, 1'b1, 1'b0, 8'h07, 8'h00);
    wait_idle("saa_pair");
    issue(2, 1'b0, 1'b0, 8'h00, 8'h3C);
    wait_idle("saa_read");
    issue(3, 1'b1, 1'b0, 8'hEE, 8'h00);
    wait_idle("dev_none");

    // random traffic, sometimes with a second request hot on the heels of the first
    for (int i = 0; i < 30; i++) begin
      dev = $urandom_range(0, 3);
      wr  = 1'($urandom_range(0, 1));
      a0  = 1'($urandom_range(0, 1));
      issue(dev, wr, a0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) begin
        g = $urandom_range(0, 3);
        repeat (g) begin @(posedge fclk); #1; end
        dev_b = $urandom_range(0, 3);
        wr_b  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        issue(dev_b, wr_b, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      wait_idle("rand");
      if (exp_ovr) clear_ovr();
      g = $urandom_range(0, 4);
      repeat (g) begin @(posedge fclk); #1; end
    end

    // reset in the middle of a YM1 strobe
    issue(0, 1'b1, 1'b0, 8'h2D, 8'h00);
    n = 0;
    while (bus.ymwr_n && n < 1000) begin @(negedge fclk); n++; end
    check_eq("strobe_before_reset", bus.ymwr_n, 1'b0);
    #2 ayres_n = 1'b0;
    #1;
    check_eq("midrst_pins", pin_vec(), 8'hFC);
    check_eq("midrst_d_oe_busy", {bus.d_oe, bus.busy, bus.rd_valid}, 3'b000);
    check_eq("midrst_d_out", bus.d_out, 8'h00);
    expq.delete(); rdq.delete();
    last_consume = 0; last_idle = 0; last_r = 0; rec_until = '{0, 0}; exp_ovr = 1'b0;
    repeat (2) @(posedge fclk);
    #2 ayres_n = 1'b1;
    @(posedge fclk); #1;
    issue(0, 1'b1, 1'b0, 8'h2D, 8'h00);
    wait_idle("post_reset_write");

    repeat (3) @(posedge fclk);
    check_eq("exp_queue_drained", expq.size(), 0);
    check_eq("rd_queue_drained", rdq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
